// File: rtl/maze_game_sequencer.sv
// Round sequencer for the micromouse maze game: requests a maze, homes the
// player, times the play phase and decides win or lose.
module maze_game_sequencer #(
    parameter int unsigned GOAL_X        = 23,
    parameter int unsigned GOAL_Y        = 23,
    parameter int unsigned TICKS_PER_SEC = 50000000,
    parameter int unsigned TIME_LIMIT    = 99
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        maze_ready,
    input  logic [7:0]  player_x,
    input  logic [7:0]  player_y,
    output logic        maze_gen_start,
    output logic        player_reset,
    output logic        player_load,
    output logic [2:0]  game_state,
    output logic [15:0] move_count,
    output logic [6:0]  time_left,
    output logic        win,
    output logic        lose
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        GEN  = 3'd1,
        LOAD = 3'd2,
        PLAY = 3'd3,
        WIN  = 3'd4,
        LOSE = 3'd5
    } state_e;

    localparam logic [31:0] TICK_MAX   = 32'(TICKS_PER_SEC - 1);
    localparam logic [6:0]  TIME_INIT  = 7'(TIME_LIMIT);
    localparam logic [7:0]  GOAL_X_8   = 8'(GOAL_X);
    localparam logic [7:0]  GOAL_Y_8   = 8'(GOAL_Y);

    state_e      state_q, state_d;
    logic        start_q, start_d;
    logic        gen_pulse_q, gen_pulse_d;
    logic [15:0] move_count_q, move_count_d;
    logic [6:0]  time_left_q, time_left_d;
    logic [31:0] tick_q, tick_d;
    logic [7:0]  prev_x_q, prev_x_d;
    logic [7:0]  prev_y_q, prev_y_d;

    logic start_edge;
    logic goal_hit;
    logic moved;

    assign start_edge = start & ~start_q;
    assign goal_hit   = (player_x == GOAL_X_8) && (player_y == GOAL_Y_8);
    assign moved      = (player_x != prev_x_q) || (player_y != prev_y_q);

    // State and datapath registers; start_q resets high so a held button must be released first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            start_q      <= 1'b1;
            gen_pulse_q  <= 1'b0;
            move_count_q <= '0;
            time_left_q  <= TIME_INIT;
            tick_q       <= '0;
            prev_x_q     <= 8'd1;
            prev_y_q     <= 8'd1;
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            gen_pulse_q  <= gen_pulse_d;
            move_count_q <= move_count_d;
            time_left_q  <= time_left_d;
            tick_q       <= tick_d;
            prev_x_q     <= prev_x_d;
            prev_y_q     <= prev_y_d;
        end
    end

    // Next-state, round timer and move counter; gen_pulse_q marks the first GEN cycle.
    always_comb begin
        state_d      = state_q;
        start_d      = start;
        gen_pulse_d  = 1'b0;
        move_count_d = move_count_q;
        time_left_d  = time_left_q;
        tick_d       = tick_q;
        prev_x_d     = prev_x_q;
        prev_y_d     = prev_y_q;

        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d     = GEN;
                    gen_pulse_d = 1'b1;
                end
            end
            GEN: begin
                if (!gen_pulse_q && maze_ready) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                move_count_d = '0;
                time_left_d  = TIME_INIT;
                tick_d       = '0;
                prev_x_d     = 8'd1;
                prev_y_d     = 8'd1;
                state_d      = PLAY;
            end
            PLAY: begin
                if (tick_q == TICK_MAX) begin
                    tick_d = '0;
                    if (time_left_q != '0) begin
                        time_left_d = time_left_q - 7'd1;
                    end
                end else begin
                    tick_d = tick_q + 32'd1;
                end
                if (moved) begin
                    if (move_count_q != '1) begin
                        move_count_d = move_count_q + 16'd1;
                    end
                    prev_x_d = player_x;
                    prev_y_d = player_y;
                end
                if (goal_hit) begin
                    state_d = WIN;
                end else if (time_left_q == '0) begin
                    state_d = LOSE;
                end
            end
            WIN, LOSE: begin
                if (start_edge) begin
                    state_d     = GEN;
                    gen_pulse_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign maze_gen_start = gen_pulse_q;
    assign player_reset   = (state_q == GEN);
    assign player_load    = (state_q == LOAD);
    assign game_state     = state_q;
    assign move_count     = move_count_q;
    assign time_left      = time_left_q;
    assign win            = (state_q == WIN);
    assign lose           = (state_q == LOSE);

endmodule

// File: tb/tb_maze_game_sequencer.sv
// Bench for maze_game_sequencer: directed table, hand sequences, random
// stimulus against a cycle-level game model, and a move-count saturation run.
module tb_maze_game_sequencer;

    localparam int GX  = 23;
    localparam int GY  = 23;
    localparam int TPS = 4;
    localparam int TL  = 3;

    logic        clk;
    logic        reset, start, maze_ready;
    logic [7:0]  player_x, player_y;
    logic        maze_gen_start, player_reset, player_load, win, lose;
    logic [2:0]  game_state;
    logic [15:0] move_count;
    logic [6:0]  time_left;

    // Second instance with a long round so 0x10000 moves fit in one PLAY phase.
    logic        r2, s2, rd2;
    logic [7:0]  x2, y2;
    logic        d2_mgs, d2_prst, d2_pld, d2_win, d2_lose;
    logic [2:0]  d2_state;
    logic [15:0] d2_moves;
    logic [6:0]  d2_tl;

    maze_game_sequencer #(.GOAL_X(GX), .GOAL_Y(GY), .TICKS_PER_SEC(TPS), .TIME_LIMIT(TL)) dut (
        .clk(clk), .reset(reset), .start(start), .maze_ready(maze_ready),
        .player_x(player_x), .player_y(player_y),
        .maze_gen_start(maze_gen_start), .player_reset(player_reset), .player_load(player_load),
        .game_state(game_state), .move_count(move_count), .time_left(time_left),
        .win(win), .lose(lose)
    );

    maze_game_sequencer #(.GOAL_X(GX), .GOAL_Y(GY), .TICKS_PER_SEC(70000), .TIME_LIMIT(1)) dut_sat (
        .clk(clk), .reset(r2), .start(s2), .maze_ready(rd2),
        .player_x(x2), .player_y(y2),
        .maze_gen_start(d2_mgs), .player_reset(d2_prst), .player_load(d2_pld),
        .game_state(d2_state), .move_count(d2_moves), .time_left(d2_tl),
        .win(d2_win), .lose(d2_lose)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Game model: phases numbered as the externally visible state code,
    // time remaining derived from the number of PLAY cycles elapsed.
    int m_state, m_moves, m_pc, m_px, m_py;
    bit m_first, m_sp;

    function automatic int tl_of(input int pc);
        int secs;
        secs = pc / TPS;
        return (secs >= TL) ? 0 : TL - secs;
    endfunction

    task automatic model_step(input bit r, input bit s, input bit rd, input int x, input int y);
        bit edge_s;
        int tl;
        if (r) begin
            m_state = 0; m_first = 0; m_sp = 1;
            m_moves = 0; m_pc = 0; m_px = 1; m_py = 1;
        end else begin
            edge_s = s && !m_sp;
            m_sp = s;
            case (m_state)
                0: if (edge_s) begin m_state = 1; m_first = 1; end
                1: begin
                    if (!m_first && rd) m_state = 2;
                    m_first = 0;
                end
                2: begin
                    m_moves = 0; m_pc = 0; m_px = 1; m_py = 1; m_state = 3;
                end
                3: begin
                    tl = tl_of(m_pc);
                    m_pc++;
                    if (x != m_px || y != m_py) begin
                        if (m_moves < 65535) m_moves++;
                        m_px = x; m_py = y;
                    end
                    if (x == GX && y == GY) m_state = 4;
                    else if (tl == 0) m_state = 5;
                end
                default: if (edge_s) begin m_state = 1; m_first = 1; end
            endcase
        end
    endtask

    task automatic compare_model();
        check("model.game_state", int'(game_state), m_state);
        check("model.maze_gen_start", int'(maze_gen_start), int'(m_state == 1 && m_first));
        check("model.player_reset", int'(player_reset), int'(m_state == 1));
        check("model.player_load", int'(player_load), int'(m_state == 2));
        check("model.move_count", int'(move_count), m_moves);
        check("model.time_left", int'(time_left), tl_of(m_pc));
        check("model.win", int'(win), int'(m_state == 4));
        check("model.lose", int'(lose), int'(m_state == 5));
    endtask

    task automatic cycle(input bit r, input bit s, input bit rd, input logic [7:0] x, input logic [7:0] y);
        reset = r; start = s; maze_ready = rd; player_x = x; player_y = y;
        @(posedge clk);
        model_step(r, s, rd, int'(x), int'(y));
        #1;
        compare_model();
    endtask

    task automatic expect_now(input string name, input int st, input int mv, input int tl, input int mgs);
        check({name, ".state"}, int'(game_state), st);
        check({name, ".moves"}, int'(move_count), mv);
        check({name, ".time_left"}, int'(time_left), tl);
        check({name, ".gen_start"}, int'(maze_gen_start), mgs);
    endtask

    typedef struct {
        bit   r, s, rd;
        logic [7:0] x, y;
        int   st, mgs, mv, tl;
    } vec_t;

    vec_t tbl[25];

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1; start = 1'b1; maze_ready = 1'b0; player_x = 8'd1; player_y = 8'd1;
        r2 = 1'b1; s2 = 1'b0; rd2 = 1'b0; x2 = 8'd1; y2 = 8'd1;

        // Round start, move counting with idle gaps, ignored start in PLAY,
        // goal reached in the cycle time_left shows 0, restart from WIN.
        tbl[0] = '{1'b1, 1'b1, 1'b0, 8'd1, 8'd1, 0, 0, 0, 3};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 8'd1, 8'd1, 0, 0, 0, 3};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 8'd1, 8'd1, 0, 0, 0, 3};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 8'd1, 8'd1, 1, 1, 0, 3};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 8'd1, 8'd1, 1, 0, 0, 3};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 8'd1, 8'd1, 2, 0, 0, 3};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 8'd1, 8'd1, 3, 0, 0, 3};
        for (int k = 1; k <= 12; k++) begin
            tbl[6 + k] = '{1'b0, (k == 9), 1'b0, (k >= 7) ? 8'd3 : 8'd2, 8'd1,
                           3, 0, (k >= 7) ? 2 : 1, 3 - k / 4};
        end
        tbl[19] = '{1'b0, 1'b0, 1'b0, 8'd23, 8'd23, 4, 0, 3, 0};
        tbl[20] = '{1'b0, 1'b0, 1'b0, 8'd5,  8'd5,  4, 0, 3, 0};
        tbl[21] = '{1'b0, 1'b1, 1'b0, 8'd5,  8'd5,  1, 1, 3, 0};
        tbl[22] = '{1'b0, 1'b0, 1'b0, 8'd5,  8'd5,  1, 0, 3, 0};
        tbl[23] = '{1'b0, 1'b0, 1'b1, 8'd5,  8'd5,  2, 0, 3, 0};
        tbl[24] = '{1'b0, 1'b0, 1'b0, 8'd1,  8'd1,  3, 0, 0, 3};

        for (int i = 0; i < 25; i++) begin
            cycle(tbl[i].r, tbl[i].s, tbl[i].rd, tbl[i].x, tbl[i].y);
            expect_now($sformatf("tbl[%0d]", i), tbl[i].st, tbl[i].mv, tbl[i].tl, tbl[i].mgs);
        end

        // Timeout: player still, time_left steps down every TPS cycles, then LOSE.
        for (int k = 1; k <= 12; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 8'd1, 8'd1);
            expect_now($sformatf("timeout[%0d]", k), 3, 0, 3 - k / 4, 0);
        end
        cycle(1'b0, 1'b0, 1'b0, 8'd1, 8'd1);
        expect_now("lose_entry", 5, 0, 0, 0);
        check("lose_entry.lose", int'(lose), 1);
        check("lose_entry.win", int'(win), 0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 8'd7 + 8'(k), 8'd1);
            expect_now($sformatf("lose_frozen[%0d]", k), 5, 0, 0, 0);
        end

        // Reset mid-PLAY with time_left=1 and move_count=5, start held through reset.
        cycle(1'b0, 1'b1, 1'b0, 8'd1, 8'd1);
        expect_now("restart_lose", 1, 0, 0, 1);
        cycle(1'b0, 1'b0, 1'b0, 8'd1, 8'd1);
        cycle(1'b0, 1'b0, 1'b1, 8'd1, 8'd1);
        check("restart.load", int'(player_load), 1);
        cycle(1'b0, 1'b0, 1'b0, 8'd1, 8'd1);
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b0, 1'b0, (k < 5) ? 8'd2 + 8'(k) : 8'd6, 8'd1);
        end
        expect_now("pre_reset", 3, 5, 1, 0);
        cycle(1'b1, 1'b1, 1'b1, 8'd9, 8'd9);
        expect_now("mid_reset", 0, 0, 3, 0);
        check("mid_reset.player_reset", int'(player_reset), 0);
        check("mid_reset.player_load", int'(player_load), 0);
        check("mid_reset.win", int'(win), 0);
        check("mid_reset.lose", int'(lose), 0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b1, 1'b1, 8'd9, 8'd9);
            expect_now($sformatf("held_start[%0d]", k), 0, 0, 3, 0);
        end
        cycle(1'b0, 1'b0, 1'b0, 8'd9, 8'd9);
        cycle(1'b0, 1'b1, 1'b0, 8'd9, 8'd9);
        expect_now("released_start", 1, 0, 3, 1);

        // Random play against the model.
        begin
            bit rs, rr;
            logic [7:0] rx, ry;
            rs = 1'b0; rx = 8'd1; ry = 8'd1;
            for (int n = 0; n < 3000; n++) begin
                rr = ($urandom_range(0, 99) == 0);
                if ($urandom_range(0, 7) == 0) rs = ~rs;
                if ($urandom_range(0, 39) == 0) begin
                    rx = 8'd23; ry = 8'd23;
                end else if ($urandom_range(0, 2) == 0) begin
                    rx = 8'($urandom_range(0, 24));
                    ry = 8'($urandom_range(0, 24));
                end
                cycle(rr, rs, $urandom_range(0, 3) != 0, rx, ry);
            end
        end

        // Saturation: more than 0xFFFF position changes in one round.
        reset = 1'b1;
        @(posedge clk); #1;
        r2 = 1'b0;
        @(posedge clk); #1;
        s2 = 1'b1;
        @(posedge clk); #1;
        s2 = 1'b0; rd2 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("sat.load", int'(d2_pld), 1);
        rd2 = 1'b0;
        @(posedge clk); #1;
        check("sat.play", int'(d2_state), 3);
        for (int k = 0; k < 65537; k++) begin
            x2 = (k % 2 == 0) ? 8'd2 : 8'd3;
            @(posedge clk); #1;
            if (k == 65533) check("sat.count_65534", int'(d2_moves), 65534);
        end
        check("sat.count_max", int'(d2_moves), 65535);
        check("sat.state", int'(d2_state), 3);
        check("sat.time_left", int'(d2_tl), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/maze_game_sequencer.md
Name: maze_game_sequencer

Overview:
- Top-level game controller for the micromouse maze game.
- Sequences each round in order: maze generation request, player reset/load, timed play phase, then win/lose detection.
- Drives the load and reset of the player movement datapath. Monitors the player coordinates to count moves and detect the goal.
- Exposes game state, move count and remaining time to the display logic.

Parameters:
- GOAL_X, 23, goal cell column (0..24).
- GOAL_Y, 23, goal cell row (0..24).
- TICKS_PER_SEC, 50000000, clk cycles per game second (>=2).
- TIME_LIMIT, 99, seconds per round (1..127).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  start/restart button, level, already debounced.
- maze_ready  in  1  maze generator done, level.
- player_x  in  8  current player column from the movement datapath.
- player_y  in  8  current player row from the movement datapath.
- maze_gen_start  out  1  one-cycle pulse requesting a new maze.
- player_reset  out  1  held high to clear the movement datapath.
- player_load  out  1  one-cycle pulse to latch the maze and home the player.
- game_state  out  3  encoded FSM state.
- move_count  out  16  moves this round, saturating.
- time_left  out  7  seconds remaining.
- win  out  1  high while in WIN.
- lose  out  1  high while in LOSE.

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-high.
  - Ports are named clk and reset.
- Reset values:
  - state = IDLE; all pulses and flags = 0.
  - move_count = 0; time_left = TIME_LIMIT; tick counter = 0.
  - start_q = 1, so a start held through reset must be released before it counts.
- Start edge:
  - start_edge = start & ~start_q; start_q is registered every cycle.
  - Only start_edge advances the FSM; a held level never does.
- State encoding: IDLE=0, GEN=1, LOAD=2, PLAY=3, WIN=4, LOSE=5.
- Outputs are Moore-decoded from the registered state, except maze_gen_start.
- IDLE:
  - Outputs idle.
  - start_edge -> GEN; maze_gen_start is high in the first GEN cycle only.
- GEN:
  - player_reset = 1 for the whole state.
  - maze_ready is ignored in the first GEN cycle. The generator must drop ready within one cycle of the start pulse.
  - From the second cycle on, maze_ready = 1 -> LOAD.
- LOAD (exactly one cycle):
  - player_load = 1, player_reset = 0.
  - Clears move_count to 0, loads time_left = TIME_LIMIT, clears the tick counter.
  - Sets prev_x = 1, prev_y = 1.
  - Always -> PLAY.
- PLAY, every cycle:
  - Tick counter increments. At TICKS_PER_SEC-1 it wraps to 0 and time_left decrements if nonzero (never below 0).
  - If (player_x, player_y) != (prev_x, prev_y): move_count += 1, saturating at 0xFFFF, and prev is updated to the new coordinates.
  - Goal match (player_x==GOAL_X && player_y==GOAL_Y) -> WIN on the next edge.
  - Else time_left==0 -> LOSE.
  - Win has priority when both occur in the same cycle.
  - Goal match at cycle N gives win=1 at cycle N+1.
- WIN / LOSE:
  - move_count and time_left are frozen; the tick counter is held.
  - start_edge -> GEN, which starts a new round.
- start_edge in GEN, LOAD or PLAY is ignored (no mid-round restart).
- Reset asserted in any state returns to IDLE on the next edge with reset values, regardless of other inputs.
- Tick counter is 32 bits wide; arithmetic is unsigned.
- Any unused state encoding (6, 7) -> IDLE.

Test Plan:
All scenarios use GOAL=(23,23), TICKS_PER_SEC=4, TIME_LIMIT=3.
- Round start:
  - Stimulus: reset, then a start rising edge.
  - Required: maze_gen_start high for 1 cycle; player_reset high throughout GEN.
  - Then: assert maze_ready -> player_load for exactly 1 cycle, game_state=3, time_left=3, move_count=0.
- Move counting:
  - Stimulus: in PLAY, step player_x 1->2->3 with 5 idle cycles between steps.
  - Required: move_count=2. A coordinate held constant for many cycles adds nothing.
  - Stimulus: force 0x10000 changes.
  - Required: move_count stays 0xFFFF.
- Timeout:
  - Stimulus: hold the player still.
  - Required: time_left 3->2->1->0 every 4 cycles; lose=1 on the cycle after time_left reaches 0; counters frozen afterwards.
- Win and priority:
  - Stimulus: drive (23,23) in the same cycle time_left becomes 0.
  - Required: win=1, lose=0; move_count frozen.
- Start handling:
  - Stimulus: start held high across reset.
  - Required: no GEN until start drops and rises again.
  - Stimulus: start edge during PLAY.
  - Required: ignored.
  - Stimulus: start edge in WIN.
  - Required: new GEN pulse.
- Reset mid-operation:
  - Stimulus: assert reset in PLAY with time_left=1 and move_count=5.
  - Required: next cycle shows IDLE, move_count=0, time_left=3, all pulses 0.
